// File: rtl/decode_in_feeder_pkg.sv
// Shared types and defaults for the decode-stage instruction feeder.
package decode_in_feeder_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] instr;
        logic [DATA_W_DEF-1:0] npc;
    } feed_entry_t;

endpackage

// File: rtl/decode_in_feeder_fifo.sv
// Circular buffer of feed entries; full/empty are derived from the level counter.
module decode_in_feeder_fifo
    import decode_in_feeder_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = feed_entry_t,
    parameter int  CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_en,
    input  logic             pop_en,
    input  entry_t           push_data,
    output entry_t           head,
    output logic [CNT_W-1:0] level,
    output logic             push_ready,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    entry_t            mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   level_d = level_q + CNT_W'(1);
                2'b01:   level_d = level_q - CNT_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: stale slots are never read while level is zero.
    always_ff @(posedge clock) begin
        if (push_en && !flush && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign push_ready = (level_q != CNT_W'(DEPTH));
    assign empty      = (level_q == '0);

endmodule

// File: rtl/decode_in_feeder.sv
// Buffers instruction/NPC pairs and presents one per cycle to the decode stage,
// honouring stall, flush and an optional empty-queue bypass.
module decode_in_feeder
    import decode_in_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int BYPASS = 0,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_instr,
    input  logic [DATA_W-1:0] push_npc,
    input  logic              stall,
    input  logic              flush,
    output logic              enable_decode,
    output logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] npc_in,
    output logic [CNT_W-1:0]  level,
    output logic              overflow
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] npc;
    } entry_t;

    localparam bit USE_BYPASS = (BYPASS != 0);

    entry_t            push_entry;
    entry_t            head;
    logic              fifo_empty;
    logic              accept;
    logic              advance;
    logic              bypass_take;
    logic              pop_en;
    logic              fifo_push;

    logic              enable_q, enable_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic              overflow_q, overflow_d;

    assign push_entry  = '{instr: push_instr, npc: push_npc};
    assign accept      = push_valid && push_ready && !flush;
    assign advance     = !stall && !flush;
    assign pop_en      = advance && !fifo_empty;
    assign bypass_take = USE_BYPASS && advance && fifo_empty && accept;
    assign fifo_push   = accept && !bypass_take;

    decode_in_feeder_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push_en    (fifo_push),
        .pop_en     (pop_en),
        .push_data  (push_entry),
        .head       (head),
        .level      (level),
        .push_ready (push_ready),
        .empty      (fifo_empty)
    );

    // Output stage: data words only change when a new entry is presented.
    always_comb begin
        enable_d   = enable_q;
        dout_d     = dout_q;
        npc_d      = npc_q;
        overflow_d = overflow_q | (push_valid && !push_ready && !flush);
        if (flush) begin
            enable_d = 1'b0;
        end else if (advance) begin
            if (pop_en) begin
                enable_d = 1'b1;
                dout_d   = head.instr;
                npc_d    = head.npc;
            end else if (bypass_take) begin
                enable_d = 1'b1;
                dout_d   = push_instr;
                npc_d    = push_npc;
            end else begin
                enable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enable_q   <= 1'b0;
            dout_q     <= '0;
            npc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            dout_q     <= dout_d;
            npc_q      <= npc_d;
            overflow_q <= overflow_d;
        end
    end

    assign enable_decode = enable_q;
    assign dout          = dout_q;
    assign npc_in        = npc_q;
    assign overflow      = overflow_q;

endmodule
